// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
//   I2S receiver. sck_i/ws_i/sd_i are oversampled in the clk_i domain through
//   SYNC_STAGES-deep synchronisers. Slot logic acts only on SCK rise events.
//   The receiver locks on the first WS edge, then deserialises the left and
//   right slots, MSB first, and keeps DATA_W bits per slot. Each complete
//   left-then-right pair is presented as one signed PCM frame on a
//   valid/ready interface.
//
// Ports
//   clk_i       system clock; must be at least 4x the SCK frequency
//   rst_ni      asynchronous active-low reset
//   sck_i       I2S serial clock; asynchronous to clk_i
//   ws_i        I2S word select; WS_POL marks the left channel
//   sd_i        I2S serial data
//   left_o      left sample, two's complement; stable while valid_o = 1
//   right_o     right sample, two's complement; stable while valid_o = 1
//   valid_o     a frame is available
//   ready_i     consumer takes the frame when valid_o && ready_i
//   overrun_o   one-cycle pulse: a completed frame was dropped
//   slot_err_o  one-cycle pulse: a slot closed with a wrong bit count
// ---------------------------------------------------------------------------
module i2s_rx #(
    parameter int unsigned SCKS_PER_SLOT = 64,
    parameter int unsigned DATA_W        = 24,
    parameter logic        WS_POL        = 1'b0,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sck_i,
    input  logic              ws_i,
    input  logic              sd_i,
    output logic [DATA_W-1:0] left_o,
    output logic [DATA_W-1:0] right_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overrun_o,
    output logic              slot_err_o
);

    localparam int unsigned CNT_W = $clog2(SCKS_PER_SLOT + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SCKS_PER_SLOT);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SCKS_PER_SLOT + 1);
    localparam logic [CNT_W-1:0] CNT_KEEP = CNT_W'(DATA_W);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    // -----------------------------------------------------------------------
    // Input synchronisers and SCK rise detection
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] ws_sync_q;
    logic [SYNC_STAGES-1:0] sd_sync_q;
    logic                   sck_dly_q;

    logic sck_s_c;
    logic ws_s_c;
    logic sd_s_c;
    logic rise_c;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q <= '0;
            ws_sync_q  <= '0;
            sd_sync_q  <= '0;
            sck_dly_q  <= 1'b0;
        end else begin
            sck_sync_q <= SYNC_STAGES'({sck_sync_q, sck_i});
            ws_sync_q  <= SYNC_STAGES'({ws_sync_q, ws_i});
            sd_sync_q  <= SYNC_STAGES'({sd_sync_q, sd_i});
            sck_dly_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    // ws and sd come from the same stage as the SCK event so they stay aligned
    assign sck_s_c = sck_sync_q[SYNC_STAGES-1];
    assign ws_s_c  = ws_sync_q[SYNC_STAGES-1];
    assign sd_s_c  = sd_sync_q[SYNC_STAGES-1];
    assign rise_c  = sck_s_c & ~sck_dly_q;

    // -----------------------------------------------------------------------
    // Slot tracker: lock FSM, bit counter, shift register, slot close
    // -----------------------------------------------------------------------
    logic [0:0]        state_q,      state_d;
    logic              ws_prev_q,    ws_prev_d;
    logic              ws_seen_q,    ws_seen_d;
    logic              chan_q,       chan_d;
    logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [DATA_W-1:0] shreg_q,      shreg_d;
    logic              close_q,      close_d;
    logic              close_ok_q,   close_ok_d;
    logic              close_left_q, close_left_d;
    logic [DATA_W-1:0] word_q,       word_d;

    logic              ws_edge_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic [DATA_W-1:0] shreg_shift_c;

    // No WS edge exists until one rise has recorded a reference ws level
    assign ws_edge_c = ws_seen_q & (ws_s_c != ws_prev_q);

    assign cnt_inc_c = (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);

    // Bits past DATA_W are counted but not stored
    assign shreg_shift_c = (bit_cnt_q < CNT_KEEP) ? DATA_W'({shreg_q, sd_s_c}) : shreg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ws_prev_d    = ws_prev_q;
        ws_seen_d    = ws_seen_q;
        chan_d       = chan_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        close_d      = 1'b0;
        close_ok_d   = close_ok_q;
        close_left_d = close_left_q;
        word_d       = word_q;

        if (rise_c) begin
            ws_prev_d = ws_s_c;
            ws_seen_d = 1'b1;
            case (state_q)
                ST_UNLOCKED: begin
                    if (ws_edge_c) begin
                        state_d   = ST_LOCKED;
                        bit_cnt_d = '0;
                        chan_d    = ws_s_c;
                    end
                end
                ST_LOCKED: begin
                    shreg_d   = shreg_shift_c;
                    bit_cnt_d = cnt_inc_c;
                    // One-bit delay: the bit on a WS edge still belongs to the closing slot
                    if (ws_edge_c) begin
                        close_d      = 1'b1;
                        close_ok_d   = (cnt_inc_c == CNT_FULL);
                        close_left_d = (chan_q == WS_POL);
                        word_d       = shreg_shift_c;
                        bit_cnt_d    = '0;
                        chan_d       = ws_s_c;
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ws_prev_q    <= 1'b0;
            ws_seen_q    <= 1'b0;
            chan_q       <= 1'b0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            close_q      <= 1'b0;
            close_ok_q   <= 1'b0;
            close_left_q <= 1'b0;
            word_q       <= '0;
        end else begin
            ws_prev_q    <= ws_prev_d;
            ws_seen_q    <= ws_seen_d;
            chan_q       <= chan_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            close_q      <= close_d;
            close_ok_q   <= close_ok_d;
            close_left_q <= close_left_d;
            word_q       <= word_d;
        end
    end

    // -----------------------------------------------------------------------
    // Slot assembly: holding registers, ordering flags, error pulse
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] hold_l_q,   hold_l_d;
    logic [DATA_W-1:0] hold_r_q,   hold_r_d;
    logic              have_l_q,   have_l_d;
    logic              have_r_q,   have_r_d;
    logic              frame_q,    frame_d;
    logic              slot_err_q, slot_err_d;

    always_comb begin
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        have_l_d   = have_l_q;
        have_r_d   = have_r_q;
        frame_d    = 1'b0;
        slot_err_d = 1'b0;

        if (close_q) begin
            if (close_ok_q) begin
                if (close_left_q) begin
                    hold_l_d = word_q;
                    have_l_d = 1'b1;
                end else begin
                    hold_r_d = word_q;
                    // A right slot without a preceding left is dropped silently
                    if (have_l_q) begin
                        frame_d  = 1'b1;
                        have_l_d = 1'b0;
                        have_r_d = 1'b0;
                    end else begin
                        have_r_d = 1'b1;
                    end
                end
            end else begin
                slot_err_d = 1'b1;
                have_l_d   = 1'b0;
                have_r_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            have_l_q   <= 1'b0;
            have_r_q   <= 1'b0;
            frame_q    <= 1'b0;
            slot_err_q <= 1'b0;
        end else begin
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            have_l_q   <= have_l_d;
            have_r_q   <= have_r_d;
            frame_q    <= frame_d;
            slot_err_q <= slot_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output stage: valid/ready handshake and overrun detection
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] left_q,    left_d;
    logic [DATA_W-1:0] right_q,   right_d;
    logic              valid_q,   valid_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (frame_q) begin
            // A frame consumed in the same cycle frees the slot for the new one
            if (!valid_q || ready_i) begin
                left_d  = hold_l_q;
                right_d = hold_r_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            left_q    <= left_d;
            right_q   <= right_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign left_o     = left_q;
    assign right_o    = right_q;
    assign valid_o    = valid_q;
    assign overrun_o  = overrun_q;
    assign slot_err_o = slot_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx
//   Directed bench for i2s_rx at defaults (64 SCKs/slot, 24-bit samples,
//   left on ws = 0, 2 synchroniser stages). SCK = clk/8; the bench drives
//   SCK, WS and SD on clk falls, changing WS one SCK before the slot MSB.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck;
    logic        ws;
    logic        sd;
    logic        ready;
    logic [23:0] left;
    logic [23:0] right;
    logic        valid;
    logic        ovr;
    logic        err;

    int checks   = 0;
    int failures = 0;

    int unsigned cyc = 0;
    int unsigned close_samp_cyc = 0;
    int unsigned last_rise_cyc = 0;

    logic [23:0] acc_l[$];
    logic [23:0] acc_r[$];
    int rise_cnt  = 0;
    int ovr_cnt   = 0;
    int err_cnt   = 0;
    int hold_viol = 0;

    int base;
    int rb;
    int ob;
    int eb;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    i2s_rx #(
        .SCKS_PER_SLOT(64),
        .DATA_W       (24),
        .WS_POL       (1'b0),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .sck_i     (sck),
        .ws_i      (ws),
        .sd_i      (sd),
        .left_o    (left),
        .right_o   (right),
        .valid_o   (valid),
        .ready_i   (ready),
        .overrun_o (ovr),
        .slot_err_o(err)
    );

    // Observer: records accepted frames, valid rises and pulse counts
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [23:0] pl = '0;
    logic [23:0] prr = '0;

    always begin
        @(negedge clk);
        #1;
        if (valid && ready) begin
            acc_l.push_back(left);
            acc_r.push_back(right);
        end
        if (valid && !pv) begin
            rise_cnt++;
            last_rise_cyc = cyc;
        end
        if (ovr) ovr_cnt++;
        if (err) err_cnt++;
        if (pv && !pr && valid && (left != pl || right != prr)) hold_viol++;
        pv  = valid;
        pr  = ready;
        pl  = left;
        prr = right;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCK period: fall with new ws/sd, 4 clk low, rise, 4 clk high
    task automatic sck_period(input logic wsv, input logic sdv, input logic hook);
        sck = 1'b0;
        ws  = wsv;
        sd  = sdv;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        close_samp_cyc = cyc + 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (hook && k == 4) ready = 1'b1;
        end
    endtask

    // Periods [from, to) of an n-SCK slot; ws flips during the final period
    task automatic send_range(input logic wsv, input logic [23:0] w, input logic pad,
                              input int n, input int from, input int to, input logic hook);
        logic bv;
        for (int i = from; i < to; i++) begin
            bv = (i < 24) ? w[23-i] : pad;
            sck_period((i == n - 1) ? ~wsv : wsv, bv, hook && (i == n - 1));
        end
    endtask

    task automatic send_slot(input logic wsv, input logic [23:0] w, input logic pad,
                             input int n, input logic hook);
        send_range(wsv, w, pad, n, 0, n, hook);
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input logic pad);
        send_slot(1'b0, l, pad, 64, 1'b0);
        send_slot(1'b1, r, pad, 64, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        sck   = 1'b0;
        ws    = 1'b0;
        sd    = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_left",  64'(left),  64'h0);
        check("rst_right", 64'(right), 64'h0);
        check("rst_valid", 64'(valid), 64'h0);
        check("rst_ovr",   64'(ovr),   64'h0);
        check("rst_err",   64'(err),   64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: lock, then steady frames; first pair after lock is lost
        base = acc_l.size();
        rb   = rise_cnt;
        repeat (3) send_frame(24'h7ABCDE, 24'h812345, 1'b0);
        idle(10);
        check("t1_frames",   64'(acc_l.size() - base), 64'd2);
        check("t1_left0",    64'(acc_l[base]),         64'h7ABCDE);
        check("t1_right0",   64'(acc_r[base]),         64'h812345);
        check("t1_left1",    64'(acc_l[base+1]),       64'h7ABCDE);
        check("t1_right1",   64'(acc_r[base+1]),       64'h812345);
        check("t1_vrises",   64'(rise_cnt - rb),       64'd2);
        check("t1_latency",  64'(last_rise_cyc - close_samp_cyc), 64'd4);
        check("t1_no_err",   64'(err_cnt),             64'd0);

        // Test 2: consumer stalled for two frames
        ready = 1'b0;
        ob    = ovr_cnt;
        base  = acc_l.size();
        send_frame(24'h111111, 24'h222222, 1'b0);
        send_frame(24'h333333, 24'h444444, 1'b0);
        idle(10);
        check("t2_valid_held", 64'(valid),         64'h1);
        check("t2_left_held",  64'(left),          64'h111111);
        check("t2_right_held", 64'(right),         64'h222222);
        check("t2_overruns",   64'(ovr_cnt - ob),  64'd1);
        check("t2_stable",     64'(hold_viol),     64'd0);
        ready = 1'b1;
        @(negedge clk);
        check("t2_valid_drop", 64'(valid),                 64'h0);
        check("t2_accepted",   64'(acc_l.size() - base),   64'd1);
        check("t2_acc_left",   64'(acc_l[base]),           64'h111111);

        // Test 3: one left slot shortened to 63 SCKs
        eb   = err_cnt;
        base = acc_l.size();
        send_slot(1'b0, 24'h555555, 1'b0, 63, 1'b0);
        send_slot(1'b1, 24'h666666, 1'b0, 64, 1'b0);
        send_frame(24'h0A5A5A, 24'hF0F0F0, 1'b0);
        idle(10);
        check("t3_slot_err", 64'(err_cnt - eb),        64'd1);
        check("t3_frames",   64'(acc_l.size() - base), 64'd1);
        check("t3_left",     64'(acc_l[base]),         64'h0A5A5A);
        check("t3_right",    64'(acc_r[base]),         64'hF0F0F0);

        // Test 4: reset in the middle of a right slot
        eb   = err_cnt;
        base = acc_l.size();
        send_slot(1'b0, 24'h123456, 1'b0, 64, 1'b0);
        send_range(1'b1, 24'h654321, 1'b0, 64, 0, 30, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t4_rst_left",  64'(left),  64'h0);
        check("t4_rst_right", 64'(right), 64'h0);
        check("t4_rst_valid", 64'(valid), 64'h0);
        check("t4_rst_ovr",   64'(ovr),   64'h0);
        check("t4_rst_err",   64'(err),   64'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        send_range(1'b1, 24'h654321, 1'b0, 64, 30, 64, 1'b0);
        send_frame(24'h13579B, 24'h2468AC, 1'b0);
        idle(10);
        check("t4_frames", 64'(acc_l.size() - base), 64'd1);
        check("t4_left",   64'(acc_l[base]),         64'h13579B);
        check("t4_right",  64'(acc_r[base]),         64'h2468AC);
        check("t4_no_err", 64'(err_cnt - eb),        64'd0);

        // Test 5: ready rises in the very cycle a new frame completes
        ready = 1'b0;
        ob    = ovr_cnt;
        base  = acc_l.size();
        send_frame(24'hABCDEF, 24'hFEDCBA, 1'b0);
        idle(4);
        send_slot(1'b0, 24'h010203, 1'b0, 64, 1'b0);
        send_slot(1'b1, 24'hC0B0A0, 1'b0, 64, 1'b1);
        @(negedge clk);
        check("t5_valid_kept", 64'(valid), 64'h1);
        check("t5_left_new",   64'(left),  64'h010203);
        check("t5_right_new",  64'(right), 64'hC0B0A0);
        idle(10);
        check("t5_no_overrun", 64'(ovr_cnt - ob),        64'd0);
        check("t5_accepted",   64'(acc_l.size() - base), 64'd2);
        check("t5_acc_old",    64'(acc_l[base]),         64'hABCDEF);
        check("t5_acc_new",    64'(acc_r[base+1]),       64'hC0B0A0);

        // Test 6: all padding bits set to 1
        base = acc_l.size();
        send_frame(24'h000001, 24'hFFFFFF, 1'b1);
        idle(10);
        check("t6_frames", 64'(acc_l.size() - base), 64'd1);
        check("t6_left",   64'(acc_l[base]),         64'h000001);
        check("t6_right",  64'(acc_r[base]),         64'hFFFFFF);
        check("t6_no_err", 64'(err_cnt - eb),        64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Receiver at the far end of the I2S link driven by i2s_clock_gen.
- Samples externally supplied SCK/WS/SD in the clk_i domain (oversampled), deserialises the left and right slots, and presents signed PCM frames on a valid/ready interface toward the audio datapath.
- Detects slot-length errors and downstream overruns.

Parameters:
- SCKS_PER_SLOT, 64, SCK periods per channel slot (half WS period); must match the transmitter.
- DATA_W, 24, sample bits kept per slot (MSB-first); 1 <= DATA_W <= SCKS_PER_SLOT.
- WS_POL, 1'b0, WS level denoting the left channel.
- SYNC_STAGES, 2, synchroniser depth for sck_i/ws_i/sd_i; minimum 2.

Ports:
- clk_i  in  1  system clock; must be at least 4x the SCK frequency.
- rst_ni  in  1  asynchronous active-low reset.
- sck_i  in  1  I2S serial clock, asynchronous to clk_i.
- ws_i  in  1  I2S word select.
- sd_i  in  1  I2S serial data.
- left_o  out  DATA_W  left sample, two's complement.
- right_o  out  DATA_W  right sample, two's complement.
- valid_o  out  1  frame available.
- ready_i  in  1  consumer accepts the frame when valid_o && ready_i.
- overrun_o  out  1  one-cycle pulse: completed frame dropped because valid_o && !ready_i.
- slot_err_o  out  1  one-cycle pulse: a slot closed with a bit count != SCKS_PER_SLOT.

Behaviour:
- **Reset:** asynchronous, active-low; everything clears.
  - left_o = 0, right_o = 0, valid_o = 0, overrun_o = 0, slot_err_o = 0.
  - Synchronisers cleared to 0. Internal state UNLOCKED.
- **Input capture:** sck_i, ws_i, sd_i each pass through SYNC_STAGES flops.
  - SCK rise event = synced SCK high while its one-cycle-delayed copy is low.
  - All slot logic acts only on rise events. ws and sd are sampled from the same synchroniser stage as the event.
- **WS edge:** at a rise event, sampled ws differs from ws sampled at the previous rise event.
- **States:**
  - UNLOCKED: ignore data. Go to LOCKED on the first WS edge: bit_cnt = 0, chan = sampled ws. No slot is closed on this edge.
  - LOCKED, rise event with no WS edge: if bit_cnt < DATA_W, shift sd into the slot shift register (MSB-first). bit_cnt increments, saturating at SCKS_PER_SLOT+1.
  - LOCKED, rise event with WS edge (I2S one-bit delay): the sd bit belongs to the closing slot; shift/count it first, then close the slot.
- **Closing a slot:**
  - Bit count == SCKS_PER_SLOT: store the word in the left or right holding register per the old chan. Set the matching have_l/have_r flag.
  - Otherwise: pulse slot_err_o; clear have_l and have_r.
  - In both cases: bit_cnt = 0, chan = new ws.
- **Frame completion:** occurs when a right slot closes validly with have_l set; then clear both flags.
  - valid_o = 0, or ready_i = 1 in the same cycle: load left_o/right_o, valid_o = 1.
  - Otherwise: keep the outputs, drop the new frame, pulse overrun_o.
- **Handshake:** valid_o && ready_i with no completion clears valid_o next cycle. left_o/right_o are stable while valid_o = 1.
- **Ordering:** a frame is always left-then-right. A right slot without a preceding valid left slot is discarded silently (normal after lock).
- **Latency:** valid_o rises exactly SYNC_STAGES+2 clk_i cycles after the first clk_i edge that samples sck_i high at the closing right-slot rise (4 cycles at defaults).
- **Widths:** bit_cnt is $clog2(SCKS_PER_SLOT+2) bits. Bits beyond DATA_W are counted but not stored.
- **Mid-operation reset:** the next lock occurs on the first WS edge after release. No frame is emitted from a partially received frame.

Test Plan:
- Clock: i2s_clock_gen (SCK_DIV=8, 64 SCKs/slot) drives sck_i/ws_i. A BFM drives sd_i on SCK falls. ready_i = 1.
- Test 1: send L=24'h7ABCDE, R=24'h812345 for 3 frames.
  - First frame after lock: none.
  - Then left_o=24'h7ABCDE, right_o=24'h812345 each frame, with a one-cycle valid_o.
  - valid_o rises 4 cycles after the sampled closing SCK rise.
- Test 2: hold ready_i = 0 for 2 frames.
  - First frame held stable; second frame produces exactly one overrun_o pulse.
  - Raising ready_i with no completion drops valid_o the next cycle.
- Test 3: BFM shortens one left slot to 63 SCKs.
  - One slot_err_o pulse, no frame for that period.
  - Next full frame received correctly.
- Test 4: assert rst_ni low mid-right-slot for 5 cycles.
  - All outputs are 0 during reset.
  - The first valid frame is the first complete L+R pair after the next WS edge.
- Test 5: ready_i = 1 in the same cycle a new frame completes while valid_o = 1.
  - Outputs update to the new frame; valid_o stays 1; no overrun_o.
- Test 6: send L=24'h000001, R=24'hFFFFFF (bits 25..64 = 1).
  - Outputs are exactly 24'h000001 and 24'hFFFFFF; padding bits are ignored.
